channel_fifo: RTL and testbench
===============================

Name: channel_fifo

Overview:
- Synchronous FIFO implementing the ac_channel hardware contract: in_data/write_valid/write_ready on the producer side, out_data/read_valid/read_ready on the consumer side.
- Sits directly upstream of channel_reduce_4 and drives its in_* port group, the words it reduces.
- Also the standard channel instance between any two HLS-generated stages.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low; assertion takes effect immediately, release is synchronous to clk.
- flush  input  1  synchronous clear, active-high; empties the FIFO on the next edge.
- in_data  input  WIDTH  producer write data.
- write_valid  input  1  producer push request.
- write_ready  output  1  FIFO can accept a push (not full).
- out_data  output  WIDTH  registered popped word.
- read_valid  input  1  consumer pop request.
- read_ready  output  1  FIFO holds at least one word (not empty).
- count  output  CNT_W  current occupancy, for debug and testbench use.

Behaviour:
- State: mem[DEPTH], wr_ptr and rd_ptr (each log2(DEPTH) bits, wrapping naturally), count register, out_data register.
- Reset (rst low): wr_ptr=0, rd_ptr=0, count=0, out_data=0. Therefore write_ready=1 and read_ready=0. mem contents are not reset.
- write_ready = (count != DEPTH). read_ready = (count != 0). Both are combinational from the count register only; neither depends on write_valid or read_valid.
- push = write_valid && write_ready. On the edge: mem[wr_ptr] <= in_data, wr_ptr++.
- pop = read_valid && read_ready. On the edge: out_data <= mem[rd_ptr], rd_ptr++.
- Read latency: out_data is valid the cycle after the pop cycle. It holds that value until the next pop. channel_reduce_4 relies on this: it asserts read_valid for one cycle and samples out_data the following cycle with read_valid low.
- No bypass. A word pushed at edge T is poppable from the cycle after T (read_ready rises after T).
- count update: push only → +1; pop only → −1; both or neither → unchanged.
- Full: write_valid is ignored (no push) even when a pop occurs in the same cycle; write_ready stays low that cycle. The pop itself proceeds normally.
- Empty: read_valid is ignored; out_data keeps its previous value; rd_ptr and count are unchanged.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged. With DEPTH≥2 and count≥1, pointers never collide on the same entry in a cycle.
- Pointer wrap: pointers advance modulo DEPTH; no special case is required.
- flush (synchronous, priority over push and pop): wr_ptr=0, rd_ptr=0, count=0. out_data is retained. Any push or pop in the same cycle is discarded.
- Reset mid-operation: asynchronous clear as above; all stored words are lost. No output is X after reset.
- Width rules: in_data, out_data and mem are WIDTH bits. The protocol signals are exactly 1 bit; a multi-bit driver connected to them is truncated to bit 0 by the parent.

Decomposition:
- Shared package channel_pkg holds:
  - CHAN_WIDTH_DEFAULT = 32
  - CHAN_DEPTH_DEFAULT = 16
  - a ptr-width function (log2 of DEPTH).
- One natural sub-module, channel_fifo_mem: the simple dual-port storage array (1 write port, 1 synchronous read port, no reset). channel_fifo keeps the pointers, count, flow control and flush logic.

Test Plan:
- Reset: hold rst low 3 cycles, release → write_ready=1, read_ready=0, count=0, out_data=0.
- Order and read latency: push 1,2,3,4 on consecutive cycles; pop with one-cycle read_valid pulses → out_data is 1,2,3,4, each visible the cycle after its pulse and held until the next pop; count ends at 0.
- Full boundary (DEPTH=16): push 0..15 → write_ready=0, count=16. Push 0xDEAD with a simultaneous pop → the pop returns 0, the push is dropped, count=15. Drain the rest → 1..15, and 0xDEAD never appears.
- Empty, wrap and concurrency: pop while empty → out_data unchanged, count=0. Stream 40 words with push and pop active every cycle after the first → output sequence equals input sequence across two pointer wraps, and count stays 1 throughout.
- Flush and async reset: load 5 words, assert flush together with a push and a pop → count=0 next cycle, read_ready=0, out_data retained. Load 3 words, pulse rst low mid-cycle → count=0 immediately, without waiting for a clock edge.
- Integration: channel_fifo driving channel_reduce_4 with 7,8,9,10 pushed → the reduce writes 34 to its out channel, and the FIFO count returns to 0.

Source files
------------

// File: rtl/channel_pkg.sv
// -----------------------------------------------------------------------------
// channel_pkg
// Shared defaults and helpers for the ac_channel FIFO family.
//   CHAN_WIDTH_DEFAULT : default data word width in bits
//   CHAN_DEPTH_DEFAULT : default number of FIFO entries (power of two)
//   ptr_width()        : pointer width for a given depth (log2 of depth)
// -----------------------------------------------------------------------------
package channel_pkg;

    localparam int CHAN_WIDTH_DEFAULT = 32;
    localparam int CHAN_DEPTH_DEFAULT = 16;

    // Depth is a power of two >= 2, so $clog2 gives an exact pointer width
    // and pointers wrap naturally at DEPTH.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// -----------------------------------------------------------------------------
// channel_fifo_mem
// Simple dual-port storage for channel_fifo: one write port, one synchronous
// read port. The storage array itself is never reset; only the read-data
// register is cleared so the popped word is never X after reset.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (read-data register only)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data updates on the edge and holds otherwise
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module channel_fifo_mem
    import channel_pkg::*;
#(
    parameter int WIDTH = CHAN_WIDTH_DEFAULT,
    parameter int DEPTH = CHAN_DEPTH_DEFAULT,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/channel_fifo.sv
// -----------------------------------------------------------------------------
// channel_fifo
// Synchronous FIFO implementing the ac_channel handshake contract.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset (synchronous release)
//   flush       : synchronous clear, priority over push and pop
//   in_data     : producer write data
//   write_valid : producer push request
//   write_ready : FIFO not full
//   out_data    : registered popped word, valid the cycle after a pop, held
//   read_valid  : consumer pop request
//   read_ready  : FIFO not empty
//   count       : current occupancy
// -----------------------------------------------------------------------------
module channel_fifo
    import channel_pkg::*;
#(
    parameter int WIDTH = CHAN_WIDTH_DEFAULT,
    parameter int DEPTH = CHAN_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             write_valid,
    output logic             write_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             read_valid,
    output logic             read_ready,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Flow control looks only at the count register, so a pop in the same
    // cycle never opens write_ready on a full FIFO.
    assign write_ready = (count != CNT_W'(DEPTH));
    assign read_ready  = (count != '0);

    assign push = write_valid & write_ready;
    assign pop  = read_valid & read_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A flush discards any same-cycle pop, so out_data keeps its old value.
    channel_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push & ~flush),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (pop & ~flush),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_channel_fifo.sv
module tb_channel_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             write_valid;
    logic             write_ready;
    logic [WIDTH-1:0] out_data;
    logic             read_valid;
    logic             read_ready;
    logic [CNT_W-1:0] count;

    int n_tests;
    int n_fail;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] last_out;

    channel_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_data     (in_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .out_data    (out_data),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at that same point, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] d);
        write_valid = 1'b1;
        in_data     = d;
        tick();
        write_valid = 1'b0;
        sb.push_back(d);
    endtask

    task automatic pop_pulse_check(input string name);
        logic [WIDTH-1:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : last_out;
        read_valid = 1'b1;
        tick();
        read_valid = 1'b0;
        n_tests++;
        if (out_data !== exp) begin
            n_fail++;
            $display("FAIL %s: out_data=%h expected=%h", name, out_data, exp);
        end
        last_out = exp;
        tick();
        n_tests++;
        if (out_data !== exp) begin
            n_fail++;
            $display("FAIL %s_hold: out_data=%h expected=%h", name, out_data, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        n_tests++;
        if (write_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_write_ready: got=%b expected=1", write_ready);
        end
        n_tests++;
        if (read_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_read_ready: got=%b expected=0", read_ready);
        end
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL reset_count: got=%0d expected=0", count);
        end
        n_tests++;
        if (out_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_out_data: got=%h expected=0", out_data);
        end
        last_out = '0;
    endtask

    task automatic test_order();
        for (int i = 1; i <= 4; i++) push_one(WIDTH'(i));
        n_tests++;
        if (count !== 5'd4) begin
            n_fail++; $display("FAIL order_count_full: got=%0d expected=4", count);
        end
        for (int i = 0; i < 4; i++) pop_pulse_check("order");
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL order_count_end: got=%0d expected=0", count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push_one(WIDTH'(i));
        n_tests++;
        if (write_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_write_ready: got=%b expected=0", write_ready);
        end
        n_tests++;
        if (count !== 5'd16) begin
            n_fail++; $display("FAIL full_count: got=%0d expected=16", count);
        end
        // Push while full is dropped; the simultaneous pop proceeds.
        write_valid = 1'b1;
        in_data     = 32'hDEAD;
        read_valid  = 1'b1;
        tick();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        last_out    = sb.pop_front();
        n_tests++;
        if (out_data !== last_out) begin
            n_fail++; $display("FAIL full_pop_word: got=%h expected=%h", out_data, last_out);
        end
        n_tests++;
        if (count !== 5'd15) begin
            n_fail++; $display("FAIL full_drop_count: got=%0d expected=15", count);
        end
        for (int i = 1; i < DEPTH; i++) pop_pulse_check("full_drain");
        n_tests++;
        if (count !== 5'd0 || read_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_drain_end: count=%0d read_ready=%b expected 0/0", count, read_ready);
        end
    endtask

    task automatic test_empty();
        read_valid = 1'b1;
        tick();
        read_valid = 1'b0;
        n_tests++;
        if (out_data !== last_out) begin
            n_fail++; $display("FAIL empty_out_data: got=%h expected=%h", out_data, last_out);
        end
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL empty_count: got=%0d expected=0", count);
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] w;
        for (int k = 0; k <= 40; k++) begin
            write_valid = (k < 40);
            read_valid  = (k > 0);
            w           = 32'hA000_0000 + WIDTH'(k * 3);
            in_data     = w;
            if (k < 40) sb.push_back(w);
            tick();
            if (k > 0) begin
                last_out = sb.pop_front();
                n_tests++;
                if (out_data !== last_out) begin
                    n_fail++; $display("FAIL stream_data[%0d]: got=%h expected=%h", k, out_data, last_out);
                end
            end
            n_tests++;
            if (count !== ((k < 40) ? 5'd1 : 5'd0)) begin
                n_fail++; $display("FAIL stream_count[%0d]: got=%0d expected=%0d", k, count, (k < 40) ? 1 : 0);
            end
        end
        write_valid = 1'b0;
        read_valid  = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_one(32'h100 + WIDTH'(i));
        flush       = 1'b1;
        write_valid = 1'b1;
        in_data     = 32'h0BAD;
        read_valid  = 1'b1;
        tick();
        flush       = 1'b0;
        write_valid = 1'b0;
        read_valid  = 1'b0;
        sb.delete();
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL flush_count: got=%0d expected=0", count);
        end
        n_tests++;
        if (read_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_read_ready: got=%b expected=0", read_ready);
        end
        n_tests++;
        if (out_data !== last_out) begin
            n_fail++; $display("FAIL flush_out_data: got=%h expected=%h", out_data, last_out);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) push_one(32'h200 + WIDTH'(i));
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        last_out = '0;
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL async_reset_count: got=%0d expected=0", count);
        end
        n_tests++;
        if (read_ready !== 1'b0 || out_data !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_outputs: read_ready=%b out_data=%h expected 0/0", read_ready, out_data);
        end
        rst = 1'b1;
        tick();
    endtask

    // Behaves like channel_reduce_4 on the consumer side: one-cycle pop pulse,
    // then samples out_data the next cycle with read_valid low.
    task automatic test_integration();
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] exp_sum;
        sum     = '0;
        exp_sum = '0;
        for (int i = 7; i <= 10; i++) begin
            push_one(WIDTH'(i));
            exp_sum = exp_sum + WIDTH'(i);
        end
        for (int i = 0; i < 4; i++) begin
            read_valid = 1'b1;
            tick();
            read_valid = 1'b0;
            tick();
            sum = sum + out_data;
            last_out = sb.pop_front();
        end
        n_tests++;
        if (sum !== exp_sum || sum !== 32'd34) begin
            n_fail++; $display("FAIL integration_sum: got=%0d expected=34", sum);
        end
        n_tests++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL integration_count: got=%0d expected=0", count);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        in_data     = '0;
        write_valid = 1'b0;
        read_valid  = 1'b0;
        last_out    = '0;
        #1;
        test_reset();
        test_order();
        test_full();
        test_empty();
        test_stream();
        test_empty();
        test_flush();
        test_async_reset();
        test_integration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
